// File: rtl/dnn_pkg.sv
// Shared types and helpers for the activation/pooling datapath.
// Tile geometry is fixed here; pooling stages derive their shapes from it.
package dnn_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned SIZE   = 8;
    localparam int unsigned ROW_W  = (SIZE / 2 > 1) ? $clog2(SIZE / 2) : 1;

    typedef logic signed [DATA_W-1:0] elem_t;
    typedef elem_t [SIZE-1:0][SIZE-1:0] tile_t;
    typedef elem_t [SIZE/2-1:0] pool_row_t;
    typedef pool_row_t [SIZE/2-1:0] pool_buf_t;
    typedef logic [ROW_W-1:0] row_idx_t;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } pool_state_t;

    function automatic elem_t max2(input elem_t a, input elem_t b);
        return ($signed(a) > $signed(b)) ? a : b;
    endfunction

endpackage

// File: rtl/maxpool_2x2_tile_if.sv
// Tile-in / pooled-row-out handshake bundle for maxpool_2x2_tile.
// slave is the pooling block's view, master is the surrounding pipeline's view.
interface maxpool_2x2_tile_if;
    import dnn_pkg::*;

    logic      in_valid;
    logic      in_ready;
    tile_t     in_tile;
    logic      out_valid;
    logic      out_ready;
    pool_row_t out_row;
    row_idx_t  out_row_idx;
    logic      out_last;

    modport slave (
        input  in_valid,
        input  in_tile,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_row,
        output out_row_idx,
        output out_last
    );

    modport master (
        output in_valid,
        output in_tile,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_row,
        input  out_row_idx,
        input  out_last
    );

endinterface

// File: rtl/maxpool_2x2_tile_max4_signed.sv
// Purely combinational signed maximum of four elements (one 2x2 pooling window).
module max4_signed
    import dnn_pkg::*;
(
    input  elem_t i_a,
    input  elem_t i_b,
    input  elem_t i_c,
    input  elem_t i_d,
    output elem_t o_max
);

    elem_t w_ab;
    elem_t w_cd;

    assign w_ab  = max2(i_a, i_b);
    assign w_cd  = max2(i_c, i_d);
    assign o_max = max2(w_ab, w_cd);

endmodule

// File: rtl/maxpool_2x2_tile.sv
// 2x2 stride-2 max-pool of an activated tile, streamed out one pooled row per handshake.
// Registers the pooled tile on input handshake; allows a new tile on the final-row handshake.
module maxpool_2x2_tile
    import dnn_pkg::*;
#(
    parameter int unsigned SIZE   = dnn_pkg::SIZE,
    parameter int unsigned DATA_W = dnn_pkg::DATA_W
) (
    input  logic               clk,
    input  logic               rst_n,
    maxpool_2x2_tile_if.slave  io_bus
);

    localparam int unsigned OUT_SIZE = SIZE / 2;
    localparam row_idx_t    LAST_ROW = row_idx_t'(OUT_SIZE - 1);

    // Shapes come from dnn_pkg types, so overrides must agree with the package.
    if ((SIZE != dnn_pkg::SIZE) || (DATA_W != dnn_pkg::DATA_W) || (SIZE < 2) ||
        (SIZE % 2 != 0)) begin : g_cfg_err
        $error("maxpool_2x2_tile: SIZE/DATA_W must match dnn_pkg, SIZE even and >= 2");
    end

    pool_buf_t   w_pool;
    logic        w_in_hs;
    logic        w_out_hs;
    logic        w_row_last;
    row_idx_t    w_row_next;

    pool_state_t r_state;
    row_idx_t    r_row;
    pool_buf_t   r_buf;
    logic        r_out_valid;
    pool_row_t   r_out_row;
    row_idx_t    r_out_idx;
    logic        r_out_last;

    for (genvar gr = 0; gr < OUT_SIZE; gr++) begin : g_row
        for (genvar gc = 0; gc < OUT_SIZE; gc++) begin : g_col
            max4_signed u_max4 (
                .i_a   (io_bus.in_tile[2*gr][2*gc]),
                .i_b   (io_bus.in_tile[2*gr][2*gc+1]),
                .i_c   (io_bus.in_tile[2*gr+1][2*gc]),
                .i_d   (io_bus.in_tile[2*gr+1][2*gc+1]),
                .o_max (w_pool[gr][gc])
            );
        end
    end

    assign w_row_last = (r_row == LAST_ROW);
    assign w_row_next = r_row + row_idx_t'(1);

    // In EMIT a new tile may only land on the final-row handshake, giving bubble-free tiles.
    assign io_bus.in_ready = (r_state == IDLE) || (io_bus.out_ready && w_row_last);

    assign w_in_hs  = io_bus.in_valid && io_bus.in_ready;
    assign w_out_hs = r_out_valid && io_bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_row       <= '0;
            r_buf       <= '0;
            r_out_valid <= 1'b0;
            r_out_row   <= '0;
            r_out_idx   <= '0;
            r_out_last  <= 1'b0;
        end else if (w_in_hs) begin
            // Reached from IDLE, or from EMIT only together with the last-row handshake.
            r_state     <= EMIT;
            r_buf       <= w_pool;
            r_row       <= '0;
            r_out_valid <= 1'b1;
            r_out_row   <= w_pool[0];
            r_out_idx   <= '0;
            r_out_last  <= (LAST_ROW == '0);
        end else if ((r_state == EMIT) && w_out_hs) begin
            if (!w_row_last) begin
                r_row      <= w_row_next;
                r_out_row  <= r_buf[w_row_next];
                r_out_idx  <= w_row_next;
                r_out_last <= (w_row_next == LAST_ROW);
            end else begin
                r_state     <= IDLE;
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
        end
    end

    assign io_bus.out_valid   = r_out_valid;
    assign io_bus.out_row     = r_out_row;
    assign io_bus.out_row_idx = r_out_idx;
    assign io_bus.out_last    = r_out_last;

endmodule

// File: tb/tb_maxpool_2x2_tile.sv
// Bench for maxpool_2x2_tile: directed tiles checked against a queue-based pooling model.
module tb_maxpool_2x2_tile;
    import dnn_pkg::*;

    localparam int OUT_N = SIZE / 2;
    localparam int CHK_W = $bits(pool_row_t);

    typedef struct {
        pool_row_t row;
        row_idx_t  idx;
        logic      last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    maxpool_2x2_tile_if bus ();

    maxpool_2x2_tile #(
        .SIZE   (SIZE),
        .DATA_W (DATA_W)
    ) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus)
    );

    int        n_vec = 0;
    int        n_bad = 0;
    exp_t      exp_q[$];
    pool_buf_t cmp_p;
    logic      exp_ready;

    task automatic check(input string name, input logic [CHK_W-1:0] got,
                         input logic [CHK_W-1:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Reference pooling: plain max over each 2x2 window.
    function automatic pool_buf_t model_pool(input tile_t t);
        pool_buf_t p;
        elem_t     win[4];
        elem_t     m;
        for (int r = 0; r < OUT_N; r++) begin
            for (int c = 0; c < OUT_N; c++) begin
                win[0] = t[2*r][2*c];
                win[1] = t[2*r][2*c+1];
                win[2] = t[2*r+1][2*c];
                win[3] = t[2*r+1][2*c+1];
                m = win[0];
                for (int k = 1; k < 4; k++) if ($signed(win[k]) > $signed(m)) m = win[k];
                p[r][c] = m;
            end
        end
        return p;
    endfunction

    function automatic tile_t mk_tile(input int mul, input int off);
        tile_t t;
        for (int i = 0; i < SIZE; i++)
            for (int j = 0; j < SIZE; j++) t[i][j] = elem_t'((i * SIZE + j) * mul + off);
        return t;
    endfunction

    function automatic pool_row_t mk_row(input int a, input int b, input int c, input int d);
        pool_row_t r;
        r[0] = elem_t'(a);
        r[1] = elem_t'(b);
        r[2] = elem_t'(c);
        r[3] = elem_t'(d);
        return r;
    endfunction

    // Every cycle: the DUT must show the head of the expected-row queue, or nothing.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            check("rst_out_valid", CHK_W'(bus.out_valid), CHK_W'(1'b0));
            check("rst_out_row", CHK_W'(bus.out_row), CHK_W'(0));
            check("rst_out_idx", CHK_W'(bus.out_row_idx), CHK_W'(0));
            check("rst_out_last", CHK_W'(bus.out_last), CHK_W'(1'b0));
        end else begin
            exp_ready = (exp_q.size() == 0) || ((exp_q.size() == 1) && bus.out_ready);
            check("in_ready", CHK_W'(bus.in_ready), CHK_W'(exp_ready));
            if (exp_q.size() == 0) begin
                check("out_valid_idle", CHK_W'(bus.out_valid), CHK_W'(1'b0));
            end else begin
                check("out_valid", CHK_W'(bus.out_valid), CHK_W'(1'b1));
                check("out_row", CHK_W'(bus.out_row), CHK_W'(exp_q[0].row));
                check("out_row_idx", CHK_W'(bus.out_row_idx), CHK_W'(exp_q[0].idx));
                check("out_last", CHK_W'(bus.out_last), CHK_W'(exp_q[0].last));
                if (bus.out_ready) void'(exp_q.pop_front());
            end
            if (bus.in_valid && exp_ready) begin
                cmp_p = model_pool(bus.in_tile);
                for (int r = 0; r < OUT_N; r++)
                    exp_q.push_back('{row: cmp_p[r], idx: row_idx_t'(r), last: (r == OUT_N - 1)});
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send_tile(input tile_t t, input string name);
        bit ok = 1'b0;
        bus.in_tile  = t;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s_accept: in_ready never seen, required 1", name);
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (!bus.out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s_drain: out_valid stuck at 1, required 0", name);
        end
        @(posedge clk);
        #1;
    endtask

    tile_t     t_ramp, t_sgn, t_a, t_b, t_bp, t_mid;
    pool_buf_t p;

    initial begin
        t_ramp = mk_tile(1, 0);
        t_sgn  = mk_tile(1, 0);
        t_sgn[0][0] = elem_t'(-5);
        t_sgn[0][1] = elem_t'(-1);
        t_sgn[1][0] = elem_t'(-7);
        t_sgn[1][1] = elem_t'(-100);
        t_sgn[0][2] = elem_t'(32'h7FFF_FFFF);
        t_sgn[0][3] = elem_t'(0);
        t_sgn[1][2] = elem_t'(-1);
        t_sgn[1][3] = elem_t'(5);
        t_a   = mk_tile(-1, 63);
        t_b   = mk_tile(5, -100);
        t_bp  = mk_tile(3, -50);
        t_mid = mk_tile(7, 1);

        // Pin the model with hand-computed values.
        p = model_pool(t_ramp);
        check("model_ramp_r0", CHK_W'(p[0]), CHK_W'(mk_row(9, 11, 13, 15)));
        check("model_ramp_r3", CHK_W'(p[3]), CHK_W'(mk_row(57, 59, 61, 63)));
        p = model_pool(t_sgn);
        check("model_sgn_00", CHK_W'(p[0][0]), CHK_W'(elem_t'(-1)));
        check("model_sgn_01", CHK_W'(p[0][1]), CHK_W'(32'h7FFF_FFFF));

        // Reset held with a valid tile on the input.
        bus.in_valid  = 1'b1;
        bus.in_tile   = t_ramp;
        bus.out_ready = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_no_capture", CHK_W'(bus.out_valid), CHK_W'(1'b0));
        end
        @(posedge clk);
        #1;

        // Single ramp tile, rows on consecutive cycles.
        send_tile(t_ramp, "ramp");
        for (int i = 0; i < OUT_N; i++) begin
            @(negedge clk);
            check("ramp_valid", CHK_W'(bus.out_valid), CHK_W'(1'b1));
            check("ramp_idx", CHK_W'(bus.out_row_idx), CHK_W'(i));
            check("ramp_last", CHK_W'(bus.out_last), CHK_W'(i == OUT_N - 1));
            if (i == 0) check("ramp_row0", CHK_W'(bus.out_row), CHK_W'(mk_row(9, 11, 13, 15)));
            if (i == 3) check("ramp_row3", CHK_W'(bus.out_row), CHK_W'(mk_row(57, 59, 61, 63)));
        end
        @(negedge clk);
        check("ramp_done", CHK_W'(bus.out_valid), CHK_W'(1'b0));
        @(posedge clk);
        #1;

        // Signed maximum including the most positive value.
        send_tile(t_sgn, "sgn");
        @(negedge clk);
        check("sgn_p00", CHK_W'(bus.out_row[0]), CHK_W'(elem_t'(-1)));
        check("sgn_p01", CHK_W'(bus.out_row[1]), CHK_W'(32'h7FFF_FFFF));
        drain("sgn");

        // Backpressure on row 1 for five cycles.
        p = model_pool(t_bp);
        send_tile(t_bp, "bp");
        @(negedge clk);
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("bp_row", CHK_W'(bus.out_row), CHK_W'(p[1]));
            check("bp_idx", CHK_W'(bus.out_row_idx), CHK_W'(1));
            check("bp_last", CHK_W'(bus.out_last), CHK_W'(1'b0));
            check("bp_in_ready", CHK_W'(bus.in_ready), CHK_W'(1'b0));
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        drain("bp");

        // Back-to-back tiles: B lands on A's last-row handshake.
        send_tile(t_a, "b2b_a");
        bus.in_tile  = t_b;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 2 * OUT_N; i++) begin
            @(negedge clk);
            check("b2b_valid", CHK_W'(bus.out_valid), CHK_W'(1'b1));
            check("b2b_idx", CHK_W'(bus.out_row_idx), CHK_W'(i % OUT_N));
            if (i == OUT_N - 1) begin
                check("b2b_in_ready", CHK_W'(bus.in_ready), CHK_W'(1'b1));
                @(posedge clk);
                #1 bus.in_valid = 1'b0;
            end
        end
        @(negedge clk);
        check("b2b_done", CHK_W'(bus.out_valid), CHK_W'(1'b0));
        @(posedge clk);
        #1;

        // Reset after the row-1 handshake discards the rest of the tile.
        send_tile(t_mid, "mid");
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("mid_async_drop", CHK_W'(bus.out_valid), CHK_W'(1'b0));
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("mid_post_rst", CHK_W'(bus.out_valid), CHK_W'(1'b0));
        end
        @(posedge clk);
        #1;
        p = model_pool(t_ramp);
        send_tile(t_ramp, "mid_new");
        @(negedge clk);
        check("mid_new_idx", CHK_W'(bus.out_row_idx), CHK_W'(0));
        check("mid_new_row", CHK_W'(bus.out_row), CHK_W'(p[0]));
        drain("mid_new");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
